// File: rtl/shift_pkg.sv
// Shared types and constants for the iterative shift unit.
package shift_pkg;

    localparam int SHIFT_W = 32;

    typedef enum logic [1:0] {
        SHIFT_SLL = 2'd0,
        SHIFT_SRL = 2'd1,
        SHIFT_SRA = 2'd2
    } shift_op_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } shift_state_t;

endpackage

// File: rtl/shift_stage.sv
// One combinational barrel stage: when enabled, shifts by 2^k in the direction
// selected by op. The reserved op encoding shifts left.
module shift_stage
    import shift_pkg::*;
#(
    parameter int N = SHIFT_W,
    parameter int S = $clog2(N)
) (
    input  logic [N-1:0] in,
    input  logic [S-1:0] k,
    input  logic         en,
    input  logic [1:0]   op,
    output logic [N-1:0] out
);

    localparam logic [S-1:0] K_ONE = S'(1);

    logic [S-1:0] dist_s;

    assign dist_s = K_ONE << k;

    // Select the shifted operand for the current stage
    always_comb begin
        out = in;
        if (en) begin
            case (op)
                SHIFT_SLL: out = in << dist_s;
                SHIFT_SRL: out = in >> dist_s;
                SHIFT_SRA: out = N'($signed(in) >>> dist_s);
                default:   out = in << dist_s;
            endcase
        end else begin
            out = in;
        end
    end

endmodule

// File: rtl/shift_unit_iterative.sv
// Multi-cycle shifter: one barrel stage per clock over a shared stage instance,
// with valid/ready handshakes on both the operation and the result side.
module shift_unit_iterative
    import shift_pkg::*;
#(
    parameter int N = SHIFT_W,
    localparam int S = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in,
    input  logic [N-1:0] shamt,
    input  logic [1:0]   op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out,
    output logic         busy
);

    localparam logic [S-1:0] K_ONE  = S'(1);
    localparam logic [S-1:0] K_LAST = S'(S - 1);

    shift_state_t state_r, state_s;
    logic [N-1:0] acc_r, acc_s;
    logic [S-1:0] amt_r, amt_s;
    logic [1:0]   op_r, op_s;
    logic [S-1:0] k_r, k_s;
    logic [N-1:0] out_r, out_s;
    logic         in_ready_r;
    logic         out_valid_r;
    logic         busy_r;
    logic [N-1:0] stage_out_s;
    logic         unused_shamt_s;

    // Upper shift-amount bits carry no meaning for an N-bit operand
    assign unused_shamt_s = ^shamt[N-1:S];

    shift_stage #(
        .N (N),
        .S (S)
    ) u_stage (
        .in  (acc_r),
        .k   (k_r),
        .en  (amt_r[k_r]),
        .op  (op_r),
        .out (stage_out_s)
    );

    // Next-state and datapath update for the IDLE/SHIFT/DONE sequence
    always_comb begin
        state_s = state_r;
        acc_s   = acc_r;
        amt_s   = amt_r;
        op_s    = op_r;
        k_s     = k_r;
        out_s   = out_r;
        case (state_r)
            S_IDLE: begin
                if (in_valid) begin
                    acc_s   = in;
                    amt_s   = shamt[S-1:0];
                    op_s    = op;
                    k_s     = '0;
                    state_s = S_SHIFT;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_SHIFT: begin
                acc_s = stage_out_s;
                k_s   = k_r + K_ONE;
                if (k_r == K_LAST) begin
                    out_s   = stage_out_s;
                    state_s = S_DONE;
                end else begin
                    state_s = S_SHIFT;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_DONE;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State, datapath and handshake registers; outputs decoded from next state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= S_IDLE;
            acc_r       <= '0;
            amt_r       <= '0;
            op_r        <= 2'b00;
            k_r         <= '0;
            out_r       <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            acc_r       <= acc_s;
            amt_r       <= amt_s;
            op_r        <= op_s;
            k_r         <= k_s;
            out_r       <= out_s;
            in_ready_r  <= (state_s == S_IDLE);
            out_valid_r <= (state_s == S_DONE);
            busy_r      <= (state_s != S_IDLE);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign out       = out_r;

endmodule

// File: tb/tb_shift_unit_iterative.sv
// Directed bench for shift_unit_iterative: vector table plus handshake corner sequences.
module tb_shift_unit_iterative;

    localparam logic [1:0] OP_SLL = 2'd0;
    localparam logic [1:0] OP_SRL = 2'd1;
    localparam logic [1:0] OP_SRA = 2'd2;
    localparam logic [1:0] OP_RSV = 2'd3;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in;
    logic [31:0] shamt;
    logic [1:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic        busy;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic [31:0] a;
        logic [31:0] sh;
        logic [1:0]  op;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [10];

    shift_unit_iterative dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in),
        .shamt     (shamt),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op, accept it on the next edge, then count edges until out_valid.
    task automatic issue(input logic [31:0] a, input logic [31:0] sh, input logic [1:0] o,
                         output int lat);
        in       = a;
        shamt    = sh;
        op       = o;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in       = 32'hDEAD_BEEF;
        shamt    = 32'h0000_0007;
        lat      = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat;

        vecs[0] = '{32'h6cb0b7d9, 32'h00000000, OP_SLL, 32'h6cb0b7d9};
        vecs[1] = '{32'h6cb0b7d9, 32'hb6a4266d, OP_SLL, 32'h16fb2000};
        vecs[2] = '{32'h6cb0b7d9, 32'h00000008, OP_SRL, 32'h006cb0b7};
        vecs[3] = '{32'h80000000, 32'h0000001f, OP_SRA, 32'hffffffff};
        vecs[4] = '{32'h80000000, 32'h0000001f, OP_SRL, 32'h00000001};
        vecs[5] = '{32'h80000000, 32'h00000001, OP_SRA, 32'hc0000000};
        vecs[6] = '{32'h6cb0b7d9, 32'h00000004, OP_SLL, 32'hcb0b7d90};
        vecs[7] = '{32'h0000000f, 32'h00000004, OP_RSV, 32'h000000f0};
        vecs[8] = '{32'h7ffffff0, 32'h00000004, OP_SRA, 32'h07ffffff};
        vecs[9] = '{32'hf0000000, 32'h00000020, OP_SRA, 32'hf0000000};

        n_cmp     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in        = 32'h0;
        shamt     = 32'h0;
        op        = OP_SLL;
        out_ready = 1'b1;
        tick();
        tick();
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_out", out, 32'h0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].a, vecs[i].sh, vecs[i].op, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd5);
            check($sformatf("vec%0d_out", i), out, vecs[i].exp);
            tick();
            check($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
        end

        // Backpressure: result held while downstream stalls
        out_ready = 1'b0;
        issue(32'h6cb0b7d9, 32'h00000004, OP_SLL, lat);
        check("bp_latency", 32'(lat), 32'd5);
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("bp_valid%0d", c), {31'd0, out_valid}, 32'd1);
            check($sformatf("bp_out%0d", c), out, 32'hcb0b7d90);
            check($sformatf("bp_in_ready%0d", c), {31'd0, in_ready}, 32'd0);
            check($sformatf("bp_busy%0d", c), {31'd0, busy}, 32'd1);
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_valid", {31'd0, out_valid}, 32'd0);
        check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);

        // Inputs change during SHIFT: latched op must win, new op waits for DONE handshake
        in       = 32'h0000000f;
        shamt    = 32'h00000004;
        op       = OP_SLL;
        in_valid = 1'b1;
        tick();
        in       = 32'hffffffff;
        shamt    = 32'h00000000;
        lat      = 0;
        while (!out_valid && lat < 20) begin
            check("chg_in_ready_low", {31'd0, in_ready}, 32'd0);
            tick();
            lat++;
        end
        check("chg_latency", 32'(lat), 32'd5);
        check("chg_out", out, 32'h000000f0);
        tick();
        check("chg_idle_in_ready", {31'd0, in_ready}, 32'd1);
        check("chg_idle_valid", {31'd0, out_valid}, 32'd0);
        tick();
        in_valid = 1'b0;
        check("chg_second_busy", {31'd0, busy}, 32'd1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("chg_second_latency", 32'(lat), 32'd5);
        check("chg_second_out", out, 32'hffffffff);
        tick();

        // Reset at SHIFT k=2 discards the in-flight op
        in       = 32'h6cb0b7d9;
        shamt    = 32'h00000004;
        op       = OP_SLL;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        check("rst_mid_out", out, 32'h0);
        check("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        for (int c = 0; c < 6; c++) begin
            tick();
            check($sformatf("rst_no_pulse%0d", c), {31'd0, out_valid}, 32'd0);
        end
        issue(32'h6cb0b7d9, 32'h00000008, OP_SRL, lat);
        check("rst_after_latency", 32'(lat), 32'd5);
        check("rst_after_out", out, 32'h006cb0b7);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/shift_unit_iterative.md
Name: shift_unit_iterative

Overview:
- Multi-cycle 32-bit shifter. Accepts one operand/shift-amount/opcode per transaction over a valid/ready handshake and resolves the shift one barrel stage per clock: stage k conditionally shifts by 2^k.
- Sits between the decode/register-read stage and writeback. Gives area-cheap SLL/SRL/SRA where the single-cycle shift_left_logical path is too wide for timing.
- Result leaves over a second valid/ready handshake.

Parameters:
- N, 32, data width; must be a power of two, N >= 2.
- S, $clog2(N), number of barrel stages and shift-amount bits used (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- in_valid  input  1  upstream presents an operation
- in_ready  output  1  unit can accept an operation
- in  input  N  operand
- shamt  input  N  shift amount; only shamt[S-1:0] used
- op  input  2  shift_op_t: SLL / SRL / SRA
- out_valid  output  1  result available
- out_ready  input  1  downstream consumes result
- out  output  N  shifted result
- busy  output  1  high in SHIFT or DONE

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n, sampled on the rising edge of clk.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out=0, busy=0, stage counter=0, operand/amt/op registers=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, latch in→acc, shamt[S-1:0]→amt, op→op_q; clear k=0; go to SHIFT.
  - shamt[N-1:S] are ignored. shamt=0xb6a4266d behaves as 13 when N=32.
- SHIFT:
  - in_ready=0.
  - Each edge: if amt[k], acc ← stage(acc, 2^k, op_q), else acc is unchanged; k ← k+1.
  - After the edge where k=S-1, go to DONE.
  - Stage count is fixed: exactly S cycles regardless of amt (no early exit). This gives deterministic latency.
- DONE:
  - out_valid=1, out=acc, held stable while out_ready=0.
  - On an edge with out_ready=1, go to IDLE. in_ready stays 0 in DONE; no same-edge accept.
- Latency: accept on edge E0; out_valid high after edge E0+S (E5 for N=32). Throughput is 1 op per S+2 cycles with out_ready tied high.
- Stage arithmetic:
  - SLL: zero fill.
  - SRL: zero fill.
  - SRA: fill with acc[N-1]. Sign is re-read from acc each stage; this is equivalent because an arithmetic shift preserves the MSB.
- op=2'b11 (reserved) behaves as SLL.
- Inputs change during SHIFT/DONE: ignored; only latched values are used.
- rst_n=0 mid-SHIFT or mid-DONE: next edge forces full reset values. The in-flight result is discarded and out_valid never pulses.
- out outside DONE: holds its last value (0 after reset). Consumers qualify out with out_valid.

Decomposition:
- Package shift_pkg:
  - typedef enum logic [1:0] shift_op_t {SHIFT_SLL=0, SHIFT_SRL=1, SHIFT_SRA=2}.
  - typedef enum shift_state_t {S_IDLE, S_SHIFT, S_DONE}.
  - Default width constant SHIFT_W=32.
- Sub-module shift_stage:
  - Purely combinational single barrel stage.
  - Ports: in[N], amount select k, enable, op; output out[N].
  - Instantiated once and indexed by counter k; not replicated S times.
- Top-level module holds the FSM, counter and registers.

Test Plan:
- Reset, then in=0x6cb0b7d9, shamt=0, op=SLL, out_ready=1 → out_valid rises exactly 5 edges after accept; out=0x6cb0b7d9; in_ready returns to 1 one cycle later.
- in=0x6cb0b7d9, shamt=0xb6a4266d (effective 13), SLL → out=0x16fb2000. Same input with SRL, shamt=8 → out=0x006cb0b7.
- in=0x80000000, shamt=31, SRA → out=0xFFFFFFFF. Same input with SRL → out=0x00000001. in=0x80000000, shamt=1, SRA → 0xC0000000.
- Backpressure: result 0xcb0b7d90 (0x6cb0b7d9 SLL 4) with out_ready=0 for 3 cycles → out_valid and out stable, in_ready=0 throughout. out_ready=1 → IDLE next edge.
- Operand change mid-op: after accept of 0x0000000F SLL 4, drive in=0xFFFFFFFF, shamt=0, in_valid=1 during SHIFT → out=0x000000F0; second op accepted only after DONE handshake completes.
- Reset mid-op: rst_n=0 for one edge at SHIFT k=2 → out_valid=0, out=0, in_ready=1, busy=0. A subsequent op completes normally with full 5-cycle latency.
